// File: rtl/uart_baud_gen_pkg.sv
// Shared constants and helpers for the UART baud-rate generator and its
// tick divider.
package uart_baud_gen_pkg;

  localparam int BAUD_VAL_W  = 13;
  localparam int BAUD_FRAC_W = 3;
  localparam int OVERSAMPLE  = 16;
  localparam int TCNT_W      = $clog2(OVERSAMPLE);

  // Reset-select idiom: the async reset always clears state.
  // With RESET_SYNC_ALSO, sresetn also clears state synchronously.
  localparam bit RESET_ASYNC_ONLY = 1'b0;
  localparam bit RESET_SYNC_ALSO  = 1'b1;

  // When fractional divide is disabled, the fraction is treated as zero.
  function automatic logic [BAUD_FRAC_W-1:0] frac_select(
    input bit                     en,
    input logic [BAUD_FRAC_W-1:0] frac
  );
    return en ? frac : '0;
  endfunction

endpackage

// File: rtl/uart_baud_gen_tick_div16.sv
// Divides the x16 oversample tick down to a one-per-bit-time pulse.
// This is a separate module so that the RX sampler can reuse it.
module uart_tick_div16
  import uart_baud_gen_pkg::*;
(
  input  logic PCLK,
  input  logic aresetn,
  input  logic clear,
  input  logic tick_en,
  output logic xmit_pulse
);

  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(OVERSAMPLE - 1);

  logic [TCNT_W-1:0] tcnt;

  // Count oversample ticks. Pulse on the tick that wraps the counter, so that
  // the pulse always coincides with a baud tick.
  always_ff @(posedge PCLK or negedge aresetn) begin
    if (!aresetn) begin
      tcnt       <= '0;
      xmit_pulse <= 1'b0;
    end else if (clear) begin
      tcnt       <= '0;
      xmit_pulse <= 1'b0;
    end else if (tick_en) begin
      tcnt       <= tcnt + TCNT_W'(1);
      xmit_pulse <= (tcnt == TCNT_LAST);
    end else begin
      xmit_pulse <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_baud_gen.sv
// Baud-rate tick generator with a fractional divider.
// The average baud_tick period is baud_val + 1 + frac/8 PCLK cycles.
// xmit_pulse fires on every 16th baud_tick.
module uart_baud_gen
  import uart_baud_gen_pkg::*;
#(
  parameter bit BAUD_VAL_FRCTN_EN = 1'b0,
  parameter bit SYNC_RESET        = RESET_ASYNC_ONLY
) (
  input  logic                   PCLK,
  input  logic                   aresetn,
  input  logic                   sresetn,
  input  logic [BAUD_VAL_W-1:0]  baud_val,
  input  logic [BAUD_FRAC_W-1:0] baud_frac,
  input  logic                   restart,
  output logic                   baud_tick,
  output logic                   xmit_pulse
);

  logic [BAUD_VAL_W-1:0]  cnt;
  logic [BAUD_FRAC_W-1:0] acc;
  logic                   ext;
  logic [BAUD_FRAC_W-1:0] frac_eff;
  logic [BAUD_FRAC_W:0]   acc_sum;
  logic                   sync_clr;
  logic                   clr;
  logic                   terminal;

  assign frac_eff = frac_select(BAUD_VAL_FRCTN_EN, baud_frac);
  assign sync_clr = (SYNC_RESET == RESET_SYNC_ALSO) && !sresetn;
  assign clr      = sync_clr || restart;
  assign terminal = (cnt == '0) && !ext;
  assign acc_sum  = {1'b0, acc} + {1'b0, frac_eff};

  // Down-count each period. At terminal count, emit a tick and reload the
  // counter. A carry out of the fraction accumulator inserts one stretch cycle
  // before the next period starts.
  always_ff @(posedge PCLK or negedge aresetn) begin
    if (!aresetn) begin
      cnt       <= '0;
      acc       <= '0;
      ext       <= 1'b0;
      baud_tick <= 1'b0;
    end else if (clr) begin
      cnt       <= '0;
      acc       <= '0;
      ext       <= 1'b0;
      baud_tick <= 1'b0;
    end else if (cnt != '0) begin
      cnt       <= cnt - BAUD_VAL_W'(1);
      baud_tick <= 1'b0;
    end else if (ext) begin
      ext       <= 1'b0;
      baud_tick <= 1'b0;
    end else begin
      cnt       <= baud_val;
      acc       <= acc_sum[BAUD_FRAC_W-1:0];
      ext       <= acc_sum[BAUD_FRAC_W];
      baud_tick <= 1'b1;
    end
  end

  uart_tick_div16 u_tick_div16 (
    .PCLK       (PCLK),
    .aresetn    (aresetn),
    .clear      (clr),
    .tick_en    (terminal && !clr),
    .xmit_pulse (xmit_pulse)
  );

endmodule

// File: tb/tb_uart_baud_gen.sv
// Testbench for uart_baud_gen. It drives two instances with different
// parameter sets from the same stimulus:
//   dut_a: fraction enabled, synchronous reset honoured
//   dut_b: fraction forced to zero, sresetn ignored
module tb_uart_baud_gen;

  logic        PCLK;
  logic        aresetn;
  logic        sresetn;
  logic        restart;
  logic [12:0] baud_val;
  logic [2:0]  baud_frac;
  logic        tick_a, xmit_a, tick_b, xmit_b;

  int checks = 0;
  int errors = 0;
  int cyc;
  int tick_cnt [2];
  int xmit_cnt [2];
  int last_tick [2];
  int prev_tick [2];
  int last_xmit [2];

  logic [12:0] cur_bv;
  logic [2:0]  cur_bf;

  // Reference model state, one entry per DUT.
  logic [12:0] m_cnt  [2];
  logic [2:0]  m_acc  [2];
  logic        m_ext  [2];
  logic [3:0]  m_tcnt [2];
  logic        m_tick [2];
  logic        m_xmit [2];

  // Each entry holds the expected {tick_a, xmit_a, tick_b, xmit_b}.
  logic [3:0] sb_q [$];

  uart_baud_gen #(.BAUD_VAL_FRCTN_EN(1'b1), .SYNC_RESET(1'b1)) dut_a (
    .PCLK(PCLK), .aresetn(aresetn), .sresetn(sresetn), .baud_val(baud_val),
    .baud_frac(baud_frac), .restart(restart), .baud_tick(tick_a), .xmit_pulse(xmit_a)
  );

  uart_baud_gen #(.BAUD_VAL_FRCTN_EN(1'b0), .SYNC_RESET(1'b0)) dut_b (
    .PCLK(PCLK), .aresetn(aresetn), .sresetn(sresetn), .baud_val(baud_val),
    .baud_frac(baud_frac), .restart(restart), .baud_tick(tick_b), .xmit_pulse(xmit_b)
  );

  // Free-running clock: 10 time units per period.
  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = '0; m_acc[k] = '0; m_ext[k] = 1'b0;
      m_tcnt[k] = '0; m_tick[k] = 1'b0; m_xmit[k] = 1'b0;
    end
  endtask

  // Advance the model by one PCLK edge and push the expected outputs.
  task automatic model_edge();
    logic [2:0] fe;
    logic [3:0] sum;
    bit         en;
    bit         sync;
    for (int k = 0; k < 2; k++) begin
      en   = (k == 0);
      sync = (k == 0);
      fe   = en ? baud_frac : 3'd0;
      if (!aresetn || (sync && !sresetn) || restart) begin
        m_cnt[k] = '0; m_acc[k] = '0; m_ext[k] = 1'b0;
        m_tcnt[k] = '0; m_tick[k] = 1'b0; m_xmit[k] = 1'b0;
      end else if (m_cnt[k] != 0) begin
        m_cnt[k]  = m_cnt[k] - 13'd1;
        m_tick[k] = 1'b0; m_xmit[k] = 1'b0;
      end else if (m_ext[k]) begin
        m_ext[k]  = 1'b0;
        m_tick[k] = 1'b0; m_xmit[k] = 1'b0;
      end else begin
        m_tick[k] = 1'b1;
        m_xmit[k] = (m_tcnt[k] == 4'd15);
        m_tcnt[k] = m_tcnt[k] + 4'd1;
        m_cnt[k]  = baud_val;
        sum       = {1'b0, m_acc[k]} + {1'b0, fe};
        m_acc[k]  = sum[2:0];
        m_ext[k]  = sum[3];
      end
    end
    sb_q.push_back({m_tick[0], m_xmit[0], m_tick[1], m_xmit[1]});
  endtask

  task automatic applyStimulus(input logic [12:0] bv, input logic [2:0] bf,
                               input logic rs, input logic sr);
    baud_val  = bv;
    baud_frac = bf;
    restart   = rs;
    sresetn   = sr;
    model_edge();
  endtask

  task automatic checkOutput();
    logic [3:0] exp_v;
    logic [3:0] obs_v;
    cyc++;
    obs_v = {tick_a, xmit_a, tick_b, xmit_b};
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $error("[TB] FAIL scoreboard_empty cycle %0d: observed %b, required an entry", cyc, obs_v);
    end else begin
      exp_v = sb_q.pop_front();
      assert (obs_v[3:2] === exp_v[3:2]) else begin
        errors++;
        $error("[TB] FAIL dut_a_tick_xmit cycle %0d: observed %b expected %b", cyc, obs_v[3:2], exp_v[3:2]);
      end
      checks++;
      assert (obs_v[1:0] === exp_v[1:0]) else begin
        errors++;
        $error("[TB] FAIL dut_b_tick_xmit cycle %0d: observed %b expected %b", cyc, obs_v[1:0], exp_v[1:0]);
      end
    end
    if (tick_a === 1'b1) begin tick_cnt[0]++; prev_tick[0] = last_tick[0]; last_tick[0] = cyc; end
    if (tick_b === 1'b1) begin tick_cnt[1]++; prev_tick[1] = last_tick[1]; last_tick[1] = cyc; end
    if (xmit_a === 1'b1) begin xmit_cnt[0]++; last_xmit[0] = cyc; end
    if (xmit_b === 1'b1) begin xmit_cnt[1]++; last_xmit[1] = cyc; end
  endtask

  task automatic cycle(input logic rs, input logic sr);
    applyStimulus(cur_bv, cur_bf, rs, sr);
    @(posedge PCLK);
    #1;
    checkOutput();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b1);
  endtask

  task automatic clear_counts();
    cyc = 0;
    for (int k = 0; k < 2; k++) begin
      tick_cnt[k] = 0; xmit_cnt[k] = 0;
      last_tick[k] = -1; prev_tick[k] = -1; last_xmit[k] = -1;
    end
  endtask

  task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    aresetn = 1'b0; sresetn = 1'b1; restart = 1'b0;
    baud_val = '0; baud_frac = '0;
    cur_bv = 13'd3; cur_bf = 3'd0;
    model_reset();
    clear_counts();

    $display("[TB] reset state");
    run(2);
    expect_eq("reset_tick_a", tick_cnt[0], 0);

    $display("[TB] baud_val=3 frac=0 from reset release");
    aresetn = 1'b1;
    clear_counts();
    run(64);
    expect_eq("div4_ticks_in_64", tick_cnt[0], 16);
    expect_eq("div4_first_xmit_cycle", last_xmit[0], 61);
    run(64);
    expect_eq("div4_xmit_in_128", xmit_cnt[1], 2);
    expect_eq("div4_second_xmit_cycle", last_xmit[1], 125);

    $display("[TB] baud_val=3 frac=4");
    cur_bf = 3'd4;
    cycle(1'b1, 1'b1);
    clear_counts();
    run(36);
    expect_eq("frac4_ticks_in_36_a", tick_cnt[0], 8);
    expect_eq("frac4_ticks_in_36_b", tick_cnt[1], 9);
    run(1);
    expect_eq("frac4_ninth_tick_cycle", last_tick[0], 37);

    $display("[TB] baud_val=0");
    cur_bv = 13'd0; cur_bf = 3'd0;
    cycle(1'b1, 1'b1);
    clear_counts();
    run(16);
    expect_eq("div1_ticks_in_16", tick_cnt[0], 16);
    expect_eq("div1_xmit_in_16", xmit_cnt[0], 1);
    cur_bf = 3'd1;
    cycle(1'b1, 1'b1);
    clear_counts();
    run(9);
    expect_eq("div1_frac1_ticks_a", tick_cnt[0], 8);
    expect_eq("div1_frac1_ticks_b", tick_cnt[1], 9);

    $display("[TB] baud_val change mid-period");
    cur_bv = 13'd3; cur_bf = 3'd0;
    cycle(1'b1, 1'b1);
    clear_counts();
    run(3);
    cur_bv = 13'd9;
    run(22);
    expect_eq("bvchg_tick_count", tick_cnt[0], 4);
    expect_eq("bvchg_prev_tick", prev_tick[0], 15);
    expect_eq("bvchg_last_tick", last_tick[0], 25);

    $display("[TB] restart at terminal count");
    cur_bv = 13'd3;
    for (int i = 0; i < 20 && !(m_cnt[0] == 0 && !m_ext[0]); i++) run(1);
    clear_counts();
    cycle(1'b1, 1'b1);
    expect_eq("restart_no_tick", tick_cnt[0], 0);
    run(61);
    expect_eq("restart_ticks", tick_cnt[0], 16);
    expect_eq("restart_xmit_count", xmit_cnt[0], 1);
    expect_eq("restart_xmit_cycle", last_xmit[0], 62);

    $display("[TB] synchronous reset");
    cycle(1'b1, 1'b1);
    clear_counts();
    cycle(1'b0, 1'b0);
    expect_eq("sreset_a_no_tick", tick_cnt[0], 0);
    expect_eq("sreset_b_ignored", tick_cnt[1], 1);
    run(4);
    expect_eq("sreset_a_tick_cycle", last_tick[0], 2);
    expect_eq("sreset_b_tick_count", tick_cnt[1], 2);

    $display("[TB] asynchronous reset");
    cur_bv = 13'd9;
    for (int i = 0; i < 20 && m_tick[0] !== 1'b1; i++) run(1);
    aresetn = 1'b0;
    #1;
    model_reset();
    expect_eq("areset_tick_a_async", tick_a, 0);
    expect_eq("areset_tick_b_async", tick_b, 0);
    expect_eq("areset_xmit_a_async", xmit_a, 0);
    run(2);
    aresetn = 1'b1;
    clear_counts();
    run(1);
    expect_eq("areset_first_tick", tick_cnt[0], 1);
    run(4);
    aresetn = 1'b0;
    #1;
    model_reset();
    expect_eq("areset_mid_tick_a", tick_a, 0);
    run(1);
    aresetn = 1'b1;
    clear_counts();
    run(1);
    expect_eq("areset_mid_abort", tick_cnt[0], 1);
    expect_eq("areset_mid_abort_b", tick_cnt[1], 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
